// File: rtl/accum_stage.sv
// Frame accumulator: folds COUNT operands through an n_bit_adder, then
// presents the modulo-2^N sum and a sticky carry on an output handshake.

module n_bit_adder #(
  parameter int N = 32
) (
  input  logic [N-1:0] input1,
  input  logic [N-1:0] input2,
  output logic [N-1:0] answer,
  output logic         carry_out
);
  logic [N:0] full;

  assign full      = {1'b0, input1} + {1'b0, input2};
  assign answer    = full[N-1:0];
  assign carry_out = full[N];
endmodule

module accum_stage #(
  parameter int N     = 32,
  parameter int COUNT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sum,
  output logic         out_carry
);
  localparam int CW = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

  localparam logic ACCUM = 1'b0;
  localparam logic DONE  = 1'b1;

  logic          state_q, state_d;
  logic [N-1:0]  acc_q, acc_d;
  logic          sticky_q, sticky_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [N-1:0]  sum_w;
  logic          carry_w;

  n_bit_adder #(.N(N)) u_adder (
    .input1    (acc_q),
    .input2    (in_data),
    .answer    (sum_w),
    .carry_out (carry_w)
  );

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign out_sum   = acc_q;
  assign out_carry = sticky_q;

  // Carries are only remembered in sticky, never folded back into the sum.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (state_q == ACCUM) begin
      if (in_valid) begin
        acc_d    = sum_w;
        sticky_d = sticky_q | carry_w;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end else if (out_ready) begin
      acc_d    = '0;
      sticky_d = 1'b0;
      state_d  = ACCUM;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ACCUM;
      acc_q    <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: tb/tb_accum_stage.sv
// Bench for accum_stage: N=4 with COUNT=3 (dut_a) and COUNT=1 (dut_b) on shared inputs.

module tb_accum_stage;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'd0;
  logic       out_ready = 1'b1;

  logic       a_in_ready, a_out_valid, a_out_carry;
  logic [3:0] a_out_sum;
  logic       b_in_ready, b_out_valid, b_out_carry;
  logic [3:0] b_out_sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  accum_stage #(.N(4), .COUNT(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_sum(a_out_sum), .out_carry(a_out_carry)
  );

  accum_stage #(.N(4), .COUNT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_sum(b_out_sum), .out_carry(b_out_carry)
  );

  logic       rdy_v [2];
  logic       vld_v [2];
  logic       car_v [2];
  logic [3:0] sum_v [2];
  assign rdy_v[0] = a_in_ready;  assign rdy_v[1] = b_in_ready;
  assign vld_v[0] = a_out_valid; assign vld_v[1] = b_out_valid;
  assign car_v[0] = a_out_carry; assign car_v[1] = b_out_carry;
  assign sum_v[0] = a_out_sum;   assign sum_v[1] = b_out_sum;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [3:0] d);
    in_valid = 1'b1;
    in_data = d;
    tick();
    in_valid = 1'b0;
    in_data = 4'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_data = 4'd5;
    tick();
    rst_n = 1'b1;
    in_valid = 1'b0;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_a_in_ready got %0b want 1", a_in_ready); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_a_out_valid got %0b want 0", a_out_valid); end
    checks++; if (a_out_sum !== 4'd0) begin errors++; $display("FAIL reset_a_out_sum got %0d want 0", a_out_sum); end
    checks++; if (a_out_carry !== 1'b0) begin errors++; $display("FAIL reset_a_out_carry got %0b want 0", a_out_carry); end
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL reset_b_out_valid got %0b want 0", b_out_valid); end
    tick();
    checks++; if (a_out_sum !== 4'd0) begin errors++; $display("FAIL reset_edge_ignored_a got %0d want 0", a_out_sum); end
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL reset_edge_ignored_b got %0b want 0", b_out_valid); end
  endtask

  task automatic test_basic();
    do_reset();
    out_ready = 1'b1;
    send(4'd4); send(4'd1); send(4'd9);
    checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b want 1", a_out_valid); end
    checks++; if (a_out_sum !== 4'b1110) begin errors++; $display("FAIL basic_sum got %0d want 14", a_out_sum); end
    checks++; if (a_out_carry !== 1'b0) begin errors++; $display("FAIL basic_carry got %0b want 0", a_out_carry); end
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_done got %0b want 0", a_in_ready); end
    tick();
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_after got %0b want 1", a_in_ready); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_after got %0b want 0", a_out_valid); end
  endtask

  task automatic test_sticky();
    do_reset();
    out_ready = 1'b1;
    send(4'd13); send(4'd13); send(4'd0);
    checks++; if (a_out_sum !== 4'b1010) begin errors++; $display("FAIL sticky_sum got %0d want 10", a_out_sum); end
    checks++; if (a_out_carry !== 1'b1) begin errors++; $display("FAIL sticky_carry got %0b want 1", a_out_carry); end
    tick();
    send(4'd1); send(4'd2); send(4'd3);
    checks++; if (a_out_sum !== 4'b0110) begin errors++; $display("FAIL sticky_next_sum got %0d want 6", a_out_sum); end
    checks++; if (a_out_carry !== 1'b0) begin errors++; $display("FAIL sticky_cleared got %0b want 0", a_out_carry); end
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    send(4'd1); send(4'd2); send(4'd3);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = 4'($urandom);
      checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %0b want 1", i, a_out_valid); end
      checks++; if (a_out_sum !== 4'd6) begin errors++; $display("FAIL bp_sum[%0d] got %0d want 6", i, a_out_sum); end
      checks++; if (a_out_carry !== 1'b0) begin errors++; $display("FAIL bp_carry[%0d] got %0b want 0", i, a_out_carry); end
      checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got %0b want 0", i, a_in_ready); end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++; if (a_out_sum !== 4'd6) begin errors++; $display("FAIL bp_sum_release got %0d want 6", a_out_sum); end
    tick();
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after got %0b want 1", a_in_ready); end
    checks++; if (a_out_sum !== 4'd0) begin errors++; $display("FAIL bp_cleared got %0d want 0", a_out_sum); end
    send(4'd4); send(4'd1); send(4'd9);
    checks++; if (a_out_sum !== 4'd14) begin errors++; $display("FAIL bp_next_frame got %0d want 14", a_out_sum); end
    tick();
  endtask

  task automatic test_gaps();
    logic [3:0] ops [3];
    do_reset();
    out_ready = 1'b1;
    ops = '{4'd2, 4'd3, 4'd5};
    for (int i = 0; i < 3; i++) begin
      send(ops[i]);
      if (i < 2) begin
        for (int g = 0; g < 2; g++) begin
          in_valid = 1'b0;
          in_data = 4'($urandom);
          tick();
        end
      end
    end
    checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL gaps_valid got %0b want 1", a_out_valid); end
    checks++; if (a_out_sum !== 4'b1010) begin errors++; $display("FAIL gaps_sum got %0d want 10", a_out_sum); end
    checks++; if (a_out_carry !== 1'b0) begin errors++; $display("FAIL gaps_carry got %0b want 0", a_out_carry); end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    send(4'd9); send(4'd9);
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_data = 4'd7;
    tick();
    rst_n = 1'b1;
    in_valid = 1'b0;
    checks++; if (a_out_sum !== 4'd0) begin errors++; $display("FAIL rmid_sum_cleared got %0d want 0", a_out_sum); end
    send(4'd7); send(4'd7); send(4'd7);
    checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL rmid_valid got %0b want 1", a_out_valid); end
    checks++; if (a_out_sum !== 4'b0101) begin errors++; $display("FAIL rmid_sum got %0d want 5", a_out_sum); end
    checks++; if (a_out_carry !== 1'b1) begin errors++; $display("FAIL rmid_carry got %0b want 1", a_out_carry); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rdone_valid got %0b want 0", a_out_valid); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rdone_ready got %0b want 1", a_in_ready); end
    out_ready = 1'b1;
  endtask

  task automatic test_count1();
    logic [3:0] vals [3];
    do_reset();
    out_ready = 1'b1;
    vals = '{4'd15, 4'd8, 4'd0};
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data = vals[k];
      checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL c1_ready[%0d] got %0b want 1", k, b_in_ready); end
      tick();
      in_data = 4'($urandom);
      checks++; if (b_out_valid !== 1'b1) begin errors++; $display("FAIL c1_valid[%0d] got %0b want 1", k, b_out_valid); end
      checks++; if (b_out_sum !== vals[k]) begin errors++; $display("FAIL c1_sum[%0d] got %0d want %0d", k, b_out_sum, vals[k]); end
      checks++; if (b_out_carry !== 1'b0) begin errors++; $display("FAIL c1_carry[%0d] got %0b want 0", k, b_out_carry); end
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Model per DUT: integer running total; wrap occurred iff total reached 16.
  task automatic test_random();
    int  tot [2];
    int  cnt [2];
    bit  dn  [2];
    int  lim [2];
    int  exp_sum;
    bit  exp_car;
    bit  v, r;
    logic [3:0] d;
    lim = '{3, 1};
    do_reset();
    for (int m = 0; m < 2; m++) begin tot[m] = 0; cnt[m] = 0; dn[m] = 0; end
    for (int c = 0; c < 400; c++) begin
      for (int m = 0; m < 2; m++) begin
        checks++; if (rdy_v[m] !== !dn[m]) begin errors++; $display("FAIL rnd_ready[%0d] cyc %0d got %0b want %0b", m, c, rdy_v[m], !dn[m]); end
        checks++; if (vld_v[m] !== dn[m]) begin errors++; $display("FAIL rnd_valid[%0d] cyc %0d got %0b want %0b", m, c, vld_v[m], dn[m]); end
        if (dn[m]) begin
          exp_sum = tot[m] % 16;
          exp_car = (tot[m] >= 16);
          checks++; if (sum_v[m] !== 4'(exp_sum)) begin errors++; $display("FAIL rnd_sum[%0d] cyc %0d got %0d want %0d", m, c, sum_v[m], exp_sum); end
          checks++; if (car_v[m] !== exp_car) begin errors++; $display("FAIL rnd_carry[%0d] cyc %0d got %0b want %0b", m, c, car_v[m], exp_car); end
        end
      end
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 1) != 0);
      d = 4'($urandom);
      in_valid = v;
      in_data = d;
      out_ready = r;
      if ($urandom_range(0, 63) == 0) begin
        rst_n = 1'b0;
        for (int m = 0; m < 2; m++) begin tot[m] = 0; cnt[m] = 0; dn[m] = 0; end
      end else begin
        rst_n = 1'b1;
        for (int m = 0; m < 2; m++) begin
          if (!dn[m]) begin
            if (v) begin
              tot[m] += int'(d);
              cnt[m]++;
              if (cnt[m] == lim[m]) dn[m] = 1;
            end
          end else if (r) begin
            tot[m] = 0; cnt[m] = 0; dn[m] = 0;
          end
        end
      end
      tick();
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sticky();
    test_backpressure();
    test_gaps();
    test_reset_mid();
    test_count1();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/accum_stage.md
# accum_stage

Frame accumulator that sits directly downstream of `n_bit_adder` and consumes its sum and carry-out. It accepts a stream of N-bit operands over a valid/ready handshake and folds each one into a running total through an instantiated `n_bit_adder`. After COUNT operands it presents one result word with a sticky carry flag on an output valid/ready handshake, then starts the next frame.

## Interface
- N, 32, operand and result width in bits (≥1)
- COUNT, 4, operands per frame (≥1)

- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- in_valid  input  1  in_data is valid this cycle
- in_ready  output  1  block accepts an operand this cycle
- in_data  input  N  operand
- out_valid  output  1  frame result is valid
- out_ready  input  1  consumer accepts the result this cycle
- out_sum  output  N  frame sum modulo 2^N
- out_carry  output  1  sticky OR of every adder carry-out in the frame

## Operation
- State: acc[N-1:0], sticky, cnt (width max(1,$clog2(COUNT))), FSM {ACCUM, DONE}.
- Adder: one `n_bit_adder #(.N(N))` instance, input1=acc, input2=in_data. The answer and carry_out of that instance are the only add path; no `+` operator on acc.
- ACCUM:
  - in_ready=1, out_valid=0.
  - Input handshake (in_valid & in_ready): acc<=answer, sticky<=sticky|carry_out.
  - If cnt==COUNT-1: cnt<=0, go DONE. Otherwise cnt<=cnt+1.
  - No handshake: all state holds.
- DONE:
  - in_ready=0, out_valid=1, out_sum=acc, out_carry=sticky.
  - All state is frozen while out_ready=0.
  - On out_ready=1: acc<=0, sticky<=0, go ACCUM.
- Arithmetic: the sum wraps modulo 2^N. Carries are never folded back into the sum. out_carry=1 means at least one wrap occurred in the frame.
- COUNT=1: every accepted operand produces a result equal to that operand with out_carry=0, because 0+x never carries.
- in_data is ignored whenever there is no handshake. in_valid may drop mid-frame with no effect on state.
- out_sum and out_carry are registers (acc and sticky). They are not combinational from in_data.

## Timing
- Reset (rst_n=0 at an edge), from any state including mid-frame or DONE:
  - acc=0, sticky=0, cnt=0, state=ACCUM.
  - Effect visible the cycle after that edge: in_ready=1, out_valid=0, out_sum=0, out_carry=0.
  - A partial frame is discarded. A pending result is dropped.
- An input handshake on the reset edge is ignored.
- Latency: out_valid rises the cycle after the COUNT-th operand is accepted.
- out_valid stays high until the first cycle with out_ready=1 (inclusive). out_sum and out_carry are stable throughout.
- Best-case throughput: COUNT+1 cycles per frame, i.e. one DONE cycle with out_ready tied high.
- There is no input/output overlap: in_ready=0 for the entire DONE period. The first operand of the next frame is accepted no earlier than the cycle after the output handshake.
- out_ready is ignored in ACCUM.

## Test plan
- N=4, COUNT=3, out_ready=1:
  - Stimulus: operands 4, 1, 9 on consecutive cycles.
  - Required response: one cycle after the third operand, out_valid=1 with out_sum=4'b1110 and out_carry=0. in_ready=0 in that cycle and 1 the next cycle.
- N=4, COUNT=3:
  - Stimulus: operands 13, 13, 0.
  - Required response: out_sum=4'b1010, out_carry=1, showing the carry stays sticky through a later non-carrying add. The following frame 1, 2, 3 gives out_sum=4'b0110 and out_carry=0, showing sticky cleared.
- Output backpressure:
  - Stimulus: out_ready=0 for 3 cycles after out_valid rises, while in_valid=1 with changing in_data.
  - Required response: out_sum and out_carry unchanged, in_ready=0, no operand consumed. The frame completes on the out_ready pulse and the next frame starts clean.
- Input gaps:
  - Stimulus: operands 2, 3, 5 with in_valid deasserted for 2 cycles between each, and garbage in_data during the gaps.
  - Required response: out_sum=4'b1010 and out_carry=0.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 for one edge after 2 of 3 operands, then send 7, 7, 7.
  - Required response: out_sum=4'b0101 and out_carry=1, with no trace of the aborted partial sum.
  - Stimulus: repeat the reset while in DONE.
  - Required response: out_valid=0 the next cycle.
- COUNT=1, N=4:
  - Stimulus: stream 15, 8, 0 with out_ready=1.
  - Required response: results 15, 8, 0 in order, each out_carry=0, one result every 2 cycles.
